// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: single-clock CPU clock-enable generator.
// Produces a one-cycle cpu_ce pulse per CPU step in one of four runtime modes:
// full speed, programmable divide, single-step and halt. Also drives an LED
// heartbeat from a free-running counter and counts every enable it issues.
// The interpreter core stays on clk and qualifies its state updates with cpu_ce.

module cpu_clk_ctrl #(
    parameter int DIV_WIDTH = 26,
    parameter int HB_BIT    = 25,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 step,
    output logic                 cpu_ce,
    output logic                 heartbeat,
    output logic [CNT_WIDTH-1:0] ce_count
);

    // Mode encodings as seen on the mode input.
    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;
    localparam logic [1:0] MODE_HALT = 2'd3;

    logic [DIV_WIDTH-1:0] free_cnt;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_cnt_next;
    logic [1:0]           mode_q;
    logic                 step_q;
    logic                 ce_next;
    logic                 mode_change;
    logic                 step_rise;
    logic                 div_done;

    assign mode_change = (mode != mode_q);
    assign step_rise   = step & ~step_q;
    assign div_done    = (div_cnt >= div);

    // Next enable and divide count; a mode change always wins and restarts the divider.
    always_comb begin
        ce_next      = 1'b0;
        div_cnt_next = div_cnt;
        if (mode_change) begin
            ce_next      = 1'b0;
            div_cnt_next = '0;
        end else begin
            case (mode)
                MODE_RUN: begin
                    ce_next = 1'b1;
                end
                MODE_DIV: begin
                    if (div_done) begin
                        ce_next      = 1'b1;
                        div_cnt_next = '0;
                    end else begin
                        ce_next      = 1'b0;
                        div_cnt_next = div_cnt + DIV_WIDTH'(1);
                    end
                end
                MODE_STEP: begin
                    ce_next = step_rise;
                end
                default: begin
                    ce_next = 1'b0;
                end
            endcase
        end
    end

    // Free-running counter feeding the heartbeat, independent of mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_cnt <= '0;
        end else begin
            free_cnt <= free_cnt + DIV_WIDTH'(1);
        end
    end

    // Previous-cycle mode and step; reset to HALT and 1 so neither a held button nor HALT fires after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_HALT;
            step_q <= 1'b1;
        end else begin
            mode_q <= mode;
            step_q <= step;
        end
    end

    // Registered enable and divide counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ce  <= 1'b0;
            div_cnt <= '0;
        end else begin
            cpu_ce  <= ce_next;
            div_cnt <= div_cnt_next;
        end
    end

    // Debug tally of issued enables, wrapping naturally at CNT_WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_count <= '0;
        end else begin
            ce_count <= ce_count + CNT_WIDTH'(cpu_ce);
        end
    end

    assign heartbeat = free_cnt[HB_BIT];

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl.
// A cycle-by-cycle vector table covers reset, RUN, DIV, div=0, STEP and HALT
// transitions; hand-written sequences cover the long and multi-cycle cases.

module tb_cpu_clk_ctrl;

    localparam int DW = 26;
    localparam int HB = 2;
    localparam int CW = 32;

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic          step;
    logic          cpu_ce;
    logic          heartbeat;
    logic [CW-1:0] ce_count;

    int n_checks  = 0;
    int n_fail    = 0;
    int since_rst = 0;

    typedef struct {
        logic          rst;
        logic [1:0]    mode;
        logic [DW-1:0] div;
        logic          step;
        logic          exp_ce;
    } vec_t;

    vec_t vecs[$];

    cpu_clk_ctrl #(
        .DIV_WIDTH (DW),
        .HB_BIT    (HB),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .div       (div),
        .step      (step),
        .cpu_ce    (cpu_ce),
        .heartbeat (heartbeat),
        .ce_count  (ce_count)
    );

    // 10 ns board clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take one edge and settle 1 ns past it.
    task automatic applyStimulus(input logic r, input logic [1:0] m,
                                 input logic [DW-1:0] d, input logic s);
        rst  = r;
        mode = m;
        div  = d;
        step = s;
        @(posedge clk);
        #1;
        if (r) since_rst = 0;
        else   since_rst++;
    endtask

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [CW-1:0] act,
                               input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected heartbeat from the number of edges since the reset edge.
    task automatic checkHeartbeat(input string name);
        checkOutput(name, 32'(heartbeat), 32'((since_rst >> HB) & 1));
    endtask

    task automatic addVec(input logic r, input logic [1:0] m,
                          input logic [DW-1:0] d, input logic s, input logic e);
        vec_t v;
        v.rst    = r;
        v.mode   = m;
        v.div    = d;
        v.step   = s;
        v.exp_ce = e;
        vecs.push_back(v);
    endtask

    // Main test sequence.
    initial begin
        logic [CW-1:0] exp_cnt;
        logic          prev_ce;
        int            n_ce;
        logic          e;

        rst  = 1'b1;
        mode = RUN;
        div  = '0;
        step = 1'b0;

        // Vector table: reset, RUN, DIV div=2, DIV div=0, STEP, HALT, STEP.
        addVec(1, RUN,  0, 0, 0);
        addVec(0, RUN,  0, 0, 0);
        addVec(0, RUN,  0, 0, 1);
        addVec(0, RUN,  0, 0, 1);
        addVec(0, DIV,  2, 0, 0);
        addVec(0, DIV,  2, 0, 0);
        addVec(0, DIV,  2, 0, 0);
        addVec(0, DIV,  2, 0, 1);
        addVec(0, DIV,  2, 0, 0);
        addVec(0, DIV,  2, 0, 0);
        addVec(0, DIV,  2, 0, 1);
        addVec(0, DIV,  0, 0, 1);
        addVec(0, DIV,  0, 0, 1);
        addVec(0, STEP, 0, 0, 0);
        addVec(0, STEP, 0, 1, 1);
        addVec(0, STEP, 0, 1, 0);
        addVec(0, STEP, 0, 0, 0);
        addVec(0, STEP, 0, 1, 1);
        addVec(0, HALT, 0, 0, 0);
        addVec(0, HALT, 0, 1, 0);
        addVec(0, STEP, 0, 1, 0);
        addVec(0, STEP, 0, 1, 0);
        addVec(0, STEP, 0, 0, 0);
        addVec(0, STEP, 0, 1, 1);

        exp_cnt = '0;
        prev_ce = 1'b0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].div, vecs[i].step);
            checkOutput($sformatf("vec%0d cpu_ce", i), 32'(cpu_ce), 32'(vecs[i].exp_ce));
            if (vecs[i].rst) exp_cnt = '0;
            else             exp_cnt = exp_cnt + CW'(prev_ce);
            checkOutput($sformatf("vec%0d ce_count", i), ce_count, exp_cnt);
            prev_ce = vecs[i].rst ? 1'b0 : vecs[i].exp_ce;
        end

        // RUN from reset: one clear cycle, then continuous enables; 99 counted after 100 cycles.
        applyStimulus(1, RUN, 0, 0);
        checkOutput("run reset cpu_ce", 32'(cpu_ce), 32'd0);
        for (int k = 1; k <= 101; k++) begin
            applyStimulus(0, RUN, 0, 0);
            checkOutput($sformatf("run k%0d cpu_ce", k), 32'(cpu_ce), 32'(k >= 2));
            checkHeartbeat($sformatf("run k%0d heartbeat", k));
        end
        checkOutput("run ce_count", ce_count, 32'd99);

        // DIV div=3 for 41 edges: first pulse at edge 5, then every 4; 9 enables in edges 1..40.
        for (int k = 1; k <= 41; k++) begin
            applyStimulus(0, DIV, 3, 0);
            checkOutput($sformatf("div3 k%0d cpu_ce", k), 32'(cpu_ce),
                        32'((k >= 5) && (k % 4 == 1)));
        end
        checkOutput("div3 ce_count", ce_count, 32'd109);

        // DIV div=10, lowered to 2 once div_cnt reaches 7: immediate pulse, then period 3.
        applyStimulus(0, HALT, 10, 0);
        checkOutput("div10 halt cpu_ce", 32'(cpu_ce), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, DIV, 10, 0);
            checkOutput($sformatf("div10 k%0d cpu_ce", k), 32'(cpu_ce), 32'd0);
        end
        for (int k = 9; k <= 15; k++) begin
            applyStimulus(0, DIV, 2, 0);
            checkOutput($sformatf("div10to2 k%0d cpu_ce", k), 32'(cpu_ce),
                        32'((k == 9) || (k == 12) || (k == 15)));
        end

        // STEP: three single-cycle presses and a 20-cycle hold give exactly four enables.
        n_ce = 0;
        applyStimulus(0, STEP, 0, 0);
        checkOutput("step enter cpu_ce", 32'(cpu_ce), 32'd0);
        applyStimulus(0, STEP, 0, 0);
        checkOutput("step idle cpu_ce", 32'(cpu_ce), 32'd0);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, STEP, 0, 1);
            checkOutput($sformatf("step press%0d cpu_ce", p), 32'(cpu_ce), 32'd1);
            n_ce += int'(cpu_ce);
            applyStimulus(0, STEP, 0, 0);
            checkOutput($sformatf("step release%0d cpu_ce", p), 32'(cpu_ce), 32'd0);
            n_ce += int'(cpu_ce);
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, STEP, 0, 1);
            e = (k == 0);
            checkOutput($sformatf("step hold k%0d cpu_ce", k), 32'(cpu_ce), 32'(e));
            n_ce += int'(cpu_ce);
        end
        applyStimulus(0, STEP, 0, 0);
        n_ce += int'(cpu_ce);
        checkOutput("step enable total", 32'(n_ce), 32'd4);

        // Step held through reset, and an edge consumed in HALT, both give no enable.
        applyStimulus(1, STEP, 0, 1);
        checkOutput("held reset cpu_ce", 32'(cpu_ce), 32'd0);
        n_ce = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, STEP, 0, 1);
            n_ce += int'(cpu_ce);
        end
        checkOutput("held step enables", 32'(n_ce), 32'd0);
        applyStimulus(0, STEP, 0, 0);
        applyStimulus(0, STEP, 0, 0);
        applyStimulus(0, HALT, 0, 0);
        applyStimulus(0, HALT, 0, 1);
        n_ce = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, STEP, 0, 1);
            n_ce += int'(cpu_ce);
        end
        checkOutput("halt edge enables", 32'(n_ce), 32'd0);
        checkOutput("no-step ce_count", ce_count, 32'd0);

        // Reset in the middle of a DIV count clears enable, count and heartbeat.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, RUN, 0, 0);
        end
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, DIV, 5, 0);
            checkOutput($sformatf("div5 k%0d cpu_ce", k), 32'(cpu_ce), 32'd0);
        end
        checkOutput("div5 pre-reset ce_count", ce_count, 32'd3);
        checkOutput("div5 pre-reset heartbeat", 32'(heartbeat), 32'd1);
        applyStimulus(1, DIV, 5, 0);
        checkOutput("midcount reset cpu_ce", 32'(cpu_ce), 32'd0);
        checkOutput("midcount reset ce_count", ce_count, 32'd0);
        checkOutput("midcount reset heartbeat", 32'(heartbeat), 32'd0);
        applyStimulus(0, DIV, 5, 0);
        checkOutput("post-reset cpu_ce", 32'(cpu_ce), 32'd0);

        // HALT for 50 cycles: no enables, frozen count, heartbeat still running.
        applyStimulus(1, RUN, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, RUN, 0, 0);
        end
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(0, HALT, 0, 0);
            checkOutput($sformatf("halt k%0d cpu_ce", k), 32'(cpu_ce), 32'd0);
            checkOutput($sformatf("halt k%0d ce_count", k), ce_count, 32'd9);
            checkHeartbeat($sformatf("halt k%0d heartbeat", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Parametrised CPU clock-enable controller sitting between the board clock and the interpreter core at top level. It replaces the fixed free-running counter tap with a single-clock-domain enable generator that has four runtime modes: full speed, programmable divide, single-step, and halt. It also provides an LED heartbeat and a count of issued CPU enables for debug. The core always runs on `clk` and qualifies every state update with `cpu_ce`.

## Interface
- `DIV_WIDTH`, 26: width of the divide-ratio input and the internal divide counter.
- `HB_BIT`, 25: bit of the free-running counter driven onto `heartbeat`; must be < `DIV_WIDTH`.
- `CNT_WIDTH`, 32: width of the enable counter `ce_count`.
- `clk`  in  1  system clock. This is the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  0=RUN, 1=DIV, 2=STEP, 3=HALT. Sampled every cycle.
- `div`  in  DIV_WIDTH  divide ratio N. In DIV mode the enable period is N+1 cycles.
- `step`  in  1  step request, synchronous to `clk` and already debounced. A rising edge requests one enable.
- `cpu_ce`  out  1  registered CPU clock enable, high for one `clk` cycle per CPU step.
- `heartbeat`  out  1  `free_cnt[HB_BIT]`.
- `ce_count`  out  CNT_WIDTH  number of cycles `cpu_ce` has been high since reset. Wraps modulo 2^CNT_WIDTH.

## Operation
- `free_cnt` (DIV_WIDTH bits) increments every cycle and wraps. It is independent of mode.
- `mode_q` register holds the previous cycle's mode. A mode change is `mode != mode_q`.
- On a mode-change cycle: `div_cnt <= 0` and `cpu_ce <= 0`, whatever the new mode. Mode-specific behaviour starts the following cycle.
- RUN: `cpu_ce <= 1` every cycle.
- DIV:
  - If `div_cnt >= div`: `div_cnt <= 0`, `cpu_ce <= 1`.
  - Otherwise: `div_cnt <= div_cnt + 1`, `cpu_ce <= 0`.
  - Comparison is unsigned, full DIV_WIDTH.
  - `div` = 0 behaves like RUN.
  - If `div` is lowered below the current `div_cnt` mid-count, a pulse fires on the next cycle, then the new period applies. No stall and no wrap through 2^DIV_WIDTH.
  - If `div` is raised mid-count, the current count continues toward the new value.
- STEP:
  - `step_q` holds the previous `step`.
  - `cpu_ce <= step & ~step_q`. Exactly one enable per rising edge.
  - Holding `step` high produces no further enables.
- HALT: `cpu_ce <= 0`. `div_cnt` holds its value.
- `step_q <= step` every cycle in all modes. An edge that occurs outside STEP mode is therefore consumed and does not fire later.
- `ce_count <= ce_count + cpu_ce` every cycle.
- Reset (`rst` high at an edge):
  - `free_cnt`, `div_cnt`, `ce_count` = 0.
  - `cpu_ce` = 0 and `heartbeat` = 0.
  - `mode_q` = HALT, so the first cycle after reset counts as a mode change unless `mode` = HALT.
  - `step_q` = 1, so a button held through reset does not step.
- Reset mid-pulse or mid-count aborts it. No enable is issued in the cycle after a reset edge.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Mode latency: with mode changed before edge t, edge t performs the mode-change clear. RUN enables appear from edge t+1.
- DIV with `div` = N, entered before edge t: the first `cpu_ce` high follows edge t+1+N. After that, one high cycle every N+1 cycles.
- STEP: `step` rises before edge t, so `step & ~step_q` is true at edge t and `cpu_ce` is high for the cycle after edge t.
- `heartbeat` toggles every 2^HB_BIT cycles. With defaults this is a period of 2^26 cycles.

## Test plan
- Reset with `mode`=RUN, then release → `cpu_ce` = 0 for the first cycle (mode-change clear), then 1 continuously. After 100 cycles in RUN, `ce_count` = 99.
- DIV with `div`=3 for 40 cycles → `cpu_ce` high 1 cycle in every 4. First pulse at cycle 5 after entry. `ce_count` increases by 9.
- DIV with `div`=10, then at `div_cnt`=7 change `div` to 2 → pulse on the next cycle, then period 3.
- STEP, three 1-cycle `step` pulses plus one 20-cycle hold → exactly 4 enables, each 1 cycle wide, one cycle after each rising edge.
- `step` held high through reset into STEP mode → 0 enables. An edge while in HALT, followed by a switch to STEP → 0 enables.
- Reset asserted mid-DIV-count (`div`=5, `div_cnt`=4) → `cpu_ce`, `ce_count`, `heartbeat` all 0 on the next cycle.
- HALT → `cpu_ce` 0 for 50 cycles and `ce_count` unchanged, while `heartbeat` keeps toggling. Check with `HB_BIT`=2 (period 8).
